// File: rtl/dmem_portb_scheduler_if.sv
// Requester, response and memory port B signals of the port B scheduler.
// slave: the scheduler's view; master: the requesters plus memory side.
interface dmem_portb_scheduler_if #(
  parameter int unsigned ADDR_W = 12
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [STRB_W-1:0] req0_wstrb;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [STRB_W-1:0] req1_wstrb;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_rdata,
    output mem_addr, mem_wstrb, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_rdata,
    input  mem_addr, mem_wstrb, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_portb_scheduler.sv
// Port B sequencer: round-robin arbitration between two requesters, the
// addr -> we/data -> rdata timing of the memory port, and a zero-fill engine.
module dmem_portb_scheduler #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dmem_portb_scheduler_if.slave        bus,
  input  logic                         i_clear_start,
  output logic                         o_clear_busy,
  output logic                         o_clear_done
);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_CLR} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  state_t            r_state, w_state_n;
  req_t              r_req, w_req_n;
  logic              r_owner, w_owner_n;
  logic              r_last, w_last_n;
  logic              r_pend, w_pend_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;

  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
  logic [STRB_W-1:0] r_mem_wstrb, w_mem_wstrb_n;
  logic              r_mem_we, w_mem_we_n;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_n;
  logic              r_rsp0, w_rsp0_n;
  logic              r_rsp1, w_rsp1_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;

  logic              w_clr_req;
  logic              w_gnt0;
  logic              w_gnt1;

  // Grant in IDLE only; a pending or arriving clear blocks both requesters.
  // r_last = 1 means requester 1 was granted last, so requester 0 is favoured.
  always_comb begin
    w_clr_req = r_pend | i_clear_start;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    if (rst_n && (r_state == S_IDLE) && !w_clr_req) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = bus.req0_valid;
        w_gnt1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_owner_n = r_owner;
    w_last_n  = r_last;
    w_cnt_n   = r_cnt;
    w_pend_n  = r_pend;
    if (i_clear_start && (r_state != S_IDLE) && (r_state != S_CLR)) begin
      w_pend_n = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (w_clr_req) begin
          w_state_n = S_CLR;
          w_pend_n  = 1'b0;
          w_cnt_n   = '0;
        end else if (w_gnt0 || w_gnt1) begin
          w_state_n = S_ADDR;
          w_owner_n = w_gnt1;
          w_last_n  = w_gnt1;
          if (w_gnt1) begin
            w_req_n = '{we: bus.req1_we, addr: bus.req1_addr,
                        wdata: bus.req1_wdata, wstrb: bus.req1_wstrb};
          end else begin
            w_req_n = '{we: bus.req0_we, addr: bus.req0_addr,
                        wdata: bus.req0_wdata, wstrb: bus.req0_wstrb};
          end
        end
      end
      S_ADDR:  w_state_n = S_DATA;
      S_DATA:  w_state_n = S_RESP;
      S_RESP:  w_state_n = S_IDLE;
      S_CLR: begin
        if (r_cnt == CNT_W'(DEPTH)) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Port and status outputs for the next cycle, decoded from the next state.
  always_comb begin
    w_mem_addr_n  = r_mem_addr;
    w_mem_wstrb_n = '0;
    w_mem_we_n    = 1'b0;
    w_mem_wdata_n = '0;
    w_rsp0_n      = 1'b0;
    w_rsp1_n      = 1'b0;
    w_done_n      = 1'b0;
    case (w_state_n)
      S_ADDR: begin
        w_mem_addr_n  = w_req_n.addr;
        w_mem_wstrb_n = w_req_n.we ? w_req_n.wstrb : '0;
      end
      S_DATA: begin
        w_mem_addr_n  = r_req.addr;
        w_mem_wstrb_n = r_req.we ? r_req.wstrb : '0;
        w_mem_we_n    = r_req.we;
        w_mem_wdata_n = r_req.wdata;
      end
      S_RESP: begin
        w_rsp0_n = !r_owner;
        w_rsp1_n = r_owner;
      end
      S_CLR: begin
        w_mem_addr_n  = (w_cnt_n == CNT_W'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                   : w_cnt_n[ADDR_W-1:0];
        w_mem_wstrb_n = '1;
        w_mem_we_n    = (w_cnt_n != '0);
        w_done_n      = (w_cnt_n == CNT_W'(DEPTH));
      end
      default: ;
    endcase
    w_busy_n = w_pend_n | (w_state_n == S_CLR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_pend      <= 1'b0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp0      <= 1'b0;
      r_rsp1      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_req       <= w_req_n;
      r_owner     <= w_owner_n;
      r_last      <= w_last_n;
      r_pend      <= w_pend_n;
      r_cnt       <= w_cnt_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wstrb <= w_mem_wstrb_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_rsp0      <= w_rsp0_n;
      r_rsp1      <= w_rsp1_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
    end
  end

  // Memory read data is already registered by the port; pass it through in RESP.
  assign bus.rsp_rdata  = (r_state == S_RESP) ? bus.mem_rdata : '0;
  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rsp0_valid = r_rsp0;
  assign bus.rsp1_valid = r_rsp1;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wstrb  = r_mem_wstrb;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;
  assign o_clear_busy   = r_busy;
  assign o_clear_done   = r_done;

endmodule
